// File: rtl/serial_nibble_framer.sv
// Serial nibble receiver: start bit, four LSB-first data bits, optional even
// parity bit and stop bit, with one-cycle valid/error pulses per frame.
module serial_nibble_framer #(
    parameter int PARITY_EN = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Si,
    input  logic       SiEn,
    output logic [3:0] Po,
    output logic       PoValid,
    output logic       FrameErr,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] shreg;
    logic       par_err;

    // Pulses default low every cycle, so a strobed stop bit yields exactly one cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            shreg    <= 4'b0000;
            par_err  <= 1'b0;
            Po       <= 4'b0000;
            PoValid  <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            PoValid  <= 1'b0;
            FrameErr <= 1'b0;
            if (SiEn) begin
                case (state)
                    IDLE: begin
                        par_err <= 1'b0;
                        if (!Si) begin
                            state <= DATA;
                            cnt   <= 2'd0;
                        end
                    end
                    DATA: begin
                        shreg[cnt] <= Si;
                        cnt        <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        if (Si != ^shreg)
                            par_err <= 1'b1;
                        state <= STOP;
                    end
                    STOP: begin
                        if (Si && !par_err) begin
                            Po      <= shreg;
                            PoValid <= 1'b1;
                        end else begin
                            FrameErr <= 1'b1;
                        end
                        par_err <= 1'b0;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: doc/serial_nibble_framer.md
SERIAL_NIBBLE_FRAMER -- requirements
Module: serial_nibble_framer

Interface
REQ-001 Parameter PARITY_EN, default 1, meaning 1 = frame carries an even-parity bit, 0 = no parity bit.
REQ-002 Clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Rst  input  1  reset, asynchronous and active-high.
REQ-004 Si  input  1  serial line, idles high.
REQ-005 SiEn  input  1  bit strobe; Si SHALL be sampled only on edges where SiEn=1.
REQ-006 Po  output  4  last correctly received nibble; feeds the downstream 4-bit PIPO register Pi.
REQ-007 PoValid  output  1  one-cycle pulse marking a new Po value.
REQ-008 FrameErr  output  1  one-cycle pulse marking a rejected frame.
REQ-009 Busy  output  1  high while a frame is in progress.

Function
REQ-010 Frame format SHALL be: start bit 0, four data bits LSB first, parity bit only when PARITY_EN=1, stop bit 1.
REQ-011 The FSM SHALL have exactly the states IDLE, DATA, PARITY and STOP, and every transition SHALL occur only on a SiEn=1 edge.
REQ-012 IDLE: Si=0 SHALL go to DATA with the bit counter cleared; Si=1 SHALL stay in IDLE.
REQ-013 DATA: each strobed bit SHALL be written to shift-register bit [cnt]; the 2-bit counter SHALL then increment; the bit at cnt=3 SHALL move to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-014 PARITY: the strobed Si SHALL be compared with the XOR of the four data bits; a mismatch SHALL set an internal parity-error flag; the FSM SHALL then move to STOP.
REQ-015 STOP, Si=1 with no parity error: Po SHALL load the assembled nibble and PoValid SHALL pulse high for exactly one cycle, on the cycle after the stop-bit edge.
REQ-016 STOP, Si=0 or parity error: FrameErr SHALL pulse high for one cycle with the same timing as PoValid; Po SHALL remain unchanged.
REQ-017 STOP SHALL always return to IDLE, and the parity-error flag SHALL be cleared there.
REQ-018 PoValid and FrameErr SHALL never be high in the same cycle.
REQ-019 Po SHALL hold its value between valid frames and SHALL NOT change on errors or partial frames.
REQ-020 Busy SHALL be 1 exactly when the state is not IDLE, using the registered state.
REQ-021 SiEn may be high on consecutive cycles; one bit SHALL be consumed per strobed cycle with no added gaps.
REQ-022 Back-to-back frames SHALL be accepted: a start bit strobed on the edge immediately after the stop-bit edge SHALL be recognised.
REQ-023 SiEn=0 cycles inside a frame SHALL freeze the state, counter and shift register.

Reset
REQ-024 While Rst=1, the block SHALL immediately set state=IDLE, cnt=0, shift register=0, Po=4'b0000, PoValid=0, FrameErr=0, Busy=0, without waiting for a clock edge.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no PoValid or FrameErr pulse; after release, the next start bit SHALL begin a fresh frame.

Verification
REQ-026 PARITY_EN=1, strobed Si = 0,1,0,1,0,0,1 -> Po=4'b0101, one PoValid pulse, FrameErr=0, Busy high from the start-bit edge until the stop-bit edge.
REQ-027 Back-to-back frames 0,0,1,1,0,0,1 then 0,0,1,1,1,1,1 -> Po=4'b0110 then 4'b1110, two PoValid pulses, with the second start bit on the edge right after the first stop bit.
REQ-028 Frame 0,1,0,1,0,1,1 (parity wrong) -> one FrameErr pulse, no PoValid, Po keeps its previous value; the same result for a frame with stop bit 0.
REQ-029 Rst pulsed after three data bits of a frame -> Po=0, Busy=0, no pulses; the following full 4'b0101 frame is received correctly.
REQ-030 Valid frame sent with random SiEn gaps of 0-3 cycles between bits -> same Po and PoValid result as the gap-free case; with PARITY_EN=0, frame 0,0,1,1,1,1 -> Po=4'b1110.
REQ-031 Idle line Si=1 with SiEn toggling for 20 cycles -> state stays IDLE, no pulses, Busy=0.
